// File: rtl/soc_system_onchip_ram_pkg.sv
// Shared types, constants and helpers for the on-chip RAM burst bridge.
package soc_system_onchip_ram_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRdBurst,
      StWrBurst
   } state_e;

   localparam int unsigned MAX_BURST    = 16;
   // Beats returned this many cycles after the command is accepted
   localparam int unsigned READ_LATENCY = 3;

   // Word address plus one, wrapped modulo 2^width
   function automatic logic [31:0] addr_inc(input logic [31:0] addr, input int unsigned width);
      logic [31:0] mask;
      mask = (32'd1 << width) - 32'd1;
      return (addr + 32'd1) & mask;
   endfunction

endpackage

// File: rtl/soc_system_onchip_ram_rd_pipe.sv
// Read return path: tracks in-flight read beats and captures RAM q into s_readdata.
module soc_system_onchip_ram_rd_pipe
   import soc_system_onchip_ram_pkg::*;
#(
   parameter int unsigned DATA_W = 64
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              issue_i,       // a read beat is loaded onto m_* at this edge
   input  logic [DATA_W-1:0] m_readdata_i,
   output logic [DATA_W-1:0] s_readdata_o,
   output logic              s_readdatavalid_o
);

   // valid_q[0]: address on RAM, [1]: RAM q valid, [2]: s_readdata valid
   logic [READ_LATENCY-1:0] valid_q, valid_d;
   logic [DATA_W-1:0]       data_q, data_d;

   // Shift the valid token and capture q when it is known to be valid
   always_comb begin
      valid_d = {valid_q[READ_LATENCY-2:0], issue_i};
      data_d  = data_q;
      if (valid_q[READ_LATENCY-2]) begin
         data_d = m_readdata_i;
      end
   end

   // Pipeline state; reset drops any beats still in flight
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign s_readdata_o      = data_q;
   assign s_readdatavalid_o = valid_q[READ_LATENCY-1];

endmodule

// File: rtl/soc_system_onchip_ram_burst_bridge.sv
// Avalon-MM burst slave that replays each burst as one registered RAM access per cycle.
module soc_system_onchip_ram_burst_bridge
   import soc_system_onchip_ram_pkg::*;
#(
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned DATA_W  = 64,
   parameter int unsigned BE_W    = 8,
   parameter int unsigned BURST_W = 5
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [ADDR_W-1:0]  s_address,
   input  logic [BURST_W-1:0] s_burstcount,
   input  logic               s_read,
   input  logic               s_write,
   input  logic [DATA_W-1:0]  s_writedata,
   input  logic [BE_W-1:0]    s_byteenable,
   output logic               s_waitrequest,
   output logic [DATA_W-1:0]  s_readdata,
   output logic               s_readdatavalid,
   output logic               err_proto,
   output logic [ADDR_W-1:0]  m_address,
   output logic [BE_W-1:0]    m_byteenable,
   output logic               m_chipselect,
   output logic               m_write,
   output logic [DATA_W-1:0]  m_writedata,
   output logic               m_clken,
   input  logic [DATA_W-1:0]  m_readdata
);

   state_e             state_q, state_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [BURST_W-1:0] remaining_q, remaining_d;
   logic               clken_q;
   logic               err_q, err_d;

   logic [ADDR_W-1:0]  m_address_q, m_address_d;
   logic [BE_W-1:0]    m_byteenable_q, m_byteenable_d;
   logic               m_chipselect_q, m_chipselect_d;
   logic               m_write_q, m_write_d;
   logic [DATA_W-1:0]  m_writedata_q, m_writedata_d;

   logic [BURST_W-1:0] count;
   logic               count_err;
   logic [ADDR_W-1:0]  s_addr_next, addr_next;

   assign s_addr_next = ADDR_W'(addr_inc(32'(s_address), ADDR_W));
   assign addr_next   = ADDR_W'(addr_inc(32'(addr_q), ADDR_W));

   // Normalise burstcount: 0 means one beat, oversize bursts are clamped and flagged
   always_comb begin
      count     = s_burstcount;
      count_err = 1'b0;
      if (s_burstcount == '0) begin
         count = BURST_W'(1);
      end else if (s_burstcount > BURST_W'(MAX_BURST)) begin
         count     = BURST_W'(MAX_BURST);
         count_err = 1'b1;
      end
   end

   // Next state and the next RAM-side beat; chipselect/write default low (idle cycle)
   always_comb begin
      state_d        = state_q;
      addr_d         = addr_q;
      remaining_d    = remaining_q;
      err_d          = err_q;
      m_address_d    = m_address_q;
      m_byteenable_d = m_byteenable_q;
      m_writedata_d  = m_writedata_q;
      m_chipselect_d = 1'b0;
      m_write_d      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (clken_q) begin
               // A write wins when both commands are presented
               if (s_write) begin
                  m_address_d    = s_address;
                  m_byteenable_d = s_byteenable;
                  m_writedata_d  = s_writedata;
                  m_chipselect_d = 1'b1;
                  m_write_d      = 1'b1;
                  addr_d         = s_addr_next;
                  remaining_d    = count - BURST_W'(1);
                  if (count > BURST_W'(1)) begin
                     state_d = StWrBurst;
                  end
                  if (s_read || count_err) begin
                     err_d = 1'b1;
                  end
               end else if (s_read) begin
                  m_address_d    = s_address;
                  m_byteenable_d = '1;
                  m_chipselect_d = 1'b1;
                  addr_d         = s_addr_next;
                  remaining_d    = count - BURST_W'(1);
                  if (count > BURST_W'(1)) begin
                     state_d = StRdBurst;
                  end
                  if (count_err) begin
                     err_d = 1'b1;
                  end
               end
            end
         end
         StRdBurst: begin
            m_address_d    = addr_q;
            m_byteenable_d = '1;
            m_chipselect_d = 1'b1;
            addr_d         = addr_next;
            remaining_d    = remaining_q - BURST_W'(1);
            if (remaining_q == BURST_W'(1)) begin
               state_d = StIdle;
            end
         end
         StWrBurst: begin
            if (s_read) begin
               err_d = 1'b1;
            end
            if (s_write) begin
               m_address_d    = addr_q;
               m_byteenable_d = s_byteenable;
               m_writedata_d  = s_writedata;
               m_chipselect_d = 1'b1;
               m_write_d      = 1'b1;
               addr_d         = addr_next;
               remaining_d    = remaining_q - BURST_W'(1);
               if (remaining_q == BURST_W'(1)) begin
                  state_d = StIdle;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Control and RAM-side output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= StIdle;
         addr_q         <= '0;
         remaining_q    <= '0;
         clken_q        <= 1'b0;
         err_q          <= 1'b0;
         m_address_q    <= '0;
         m_byteenable_q <= '0;
         m_chipselect_q <= 1'b0;
         m_write_q      <= 1'b0;
         m_writedata_q  <= '0;
      end else begin
         state_q        <= state_d;
         addr_q         <= addr_d;
         remaining_q    <= remaining_d;
         clken_q        <= 1'b1;
         err_q          <= err_d;
         m_address_q    <= m_address_d;
         m_byteenable_q <= m_byteenable_d;
         m_chipselect_q <= m_chipselect_d;
         m_write_q      <= m_write_d;
         m_writedata_q  <= m_writedata_d;
      end
   end

   soc_system_onchip_ram_rd_pipe #(
      .DATA_W (DATA_W)
   ) u_rd_pipe (
      .clk               (clk),
      .reset_n           (reset_n),
      .issue_i           (m_chipselect_d & ~m_write_d),
      .m_readdata_i      (m_readdata),
      .s_readdata_o      (s_readdata),
      .s_readdatavalid_o (s_readdatavalid)
   );

   // Held off until the first clock after reset, and for the whole read burst
   assign s_waitrequest = ~clken_q | (state_q == StRdBurst);
   assign err_proto     = err_q;
   assign m_clken       = clken_q;
   assign m_address     = m_address_q;
   assign m_byteenable  = m_byteenable_q;
   assign m_chipselect  = m_chipselect_q;
   assign m_write       = m_write_q;
   assign m_writedata   = m_writedata_q;

endmodule

// File: tb/tb_soc_system_onchip_ram_burst_bridge.sv
// Directed bench for the RAM burst bridge with a behavioural single-port RAM behind it.
module tb_soc_system_onchip_ram_burst_bridge;

   localparam int unsigned ADDR_W  = 10;
   localparam int unsigned DATA_W  = 64;
   localparam int unsigned BE_W    = 8;
   localparam int unsigned BURST_W = 5;

   logic               clk = 1'b0;
   logic               reset_n = 1'b0;
   logic [ADDR_W-1:0]  s_address = '0;
   logic [BURST_W-1:0] s_burstcount = '0;
   logic               s_read = 1'b0;
   logic               s_write = 1'b0;
   logic [DATA_W-1:0]  s_writedata = '0;
   logic [BE_W-1:0]    s_byteenable = '0;
   logic               s_waitrequest;
   logic [DATA_W-1:0]  s_readdata;
   logic               s_readdatavalid;
   logic               err_proto;
   logic [ADDR_W-1:0]  m_address;
   logic [BE_W-1:0]    m_byteenable;
   logic               m_chipselect;
   logic               m_write;
   logic [DATA_W-1:0]  m_writedata;
   logic               m_clken;
   logic [DATA_W-1:0]  m_readdata = '0;

   soc_system_onchip_ram_burst_bridge #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .BE_W    (BE_W),
      .BURST_W (BURST_W)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .s_address       (s_address),
      .s_burstcount    (s_burstcount),
      .s_read          (s_read),
      .s_write         (s_write),
      .s_writedata     (s_writedata),
      .s_byteenable    (s_byteenable),
      .s_waitrequest   (s_waitrequest),
      .s_readdata      (s_readdata),
      .s_readdatavalid (s_readdatavalid),
      .err_proto       (err_proto),
      .m_address       (m_address),
      .m_byteenable    (m_byteenable),
      .m_chipselect    (m_chipselect),
      .m_write         (m_write),
      .m_writedata     (m_writedata),
      .m_clken         (m_clken),
      .m_readdata      (m_readdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Single-port RAM: byte-masked write, registered read
   logic [63:0] mem [1024];

   function automatic logic [63:0] merge(input logic [63:0] old_w, input logic [63:0] new_w,
                                         input logic [7:0] be);
      logic [63:0] r;
      r = old_w;
      for (int b = 0; b < 8; b++) begin
         if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
      end
      return r;
   endfunction

   always @(posedge clk) begin
      if (m_clken && m_chipselect) begin
         if (m_write) begin
            mem[m_address] <= merge(mem[m_address], m_writedata, m_byteenable);
         end else begin
            m_readdata <= mem[m_address];
         end
      end
   end

   // Observers
   logic [63:0] rd_data_q [$];
   int          rd_cyc_q [$];
   int          rd_issue_q [$];
   int          wr_addr_q [$];

   always @(negedge clk) begin
      if (s_readdatavalid) begin
         rd_data_q.push_back(s_readdata);
         rd_cyc_q.push_back(cyc);
      end
      if (m_chipselect && !m_write) rd_issue_q.push_back(int'(m_address));
      if (m_chipselect && m_write) wr_addr_q.push_back(int'(m_address));
   end

   int n_checks = 0;
   int n_fails  = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] rd_data(input int i);
      if (rd_data_q.size() > i) return rd_data_q[i];
      return 'x;
   endfunction

   function automatic int rd_cyc(input int i);
      if (rd_cyc_q.size() > i) return rd_cyc_q[i];
      return -1;
   endfunction

   function automatic int rd_issue(input int i);
      if (rd_issue_q.size() > i) return rd_issue_q[i];
      return -1;
   endfunction

   function automatic int wr_addr(input int i);
      if (wr_addr_q.size() > i) return wr_addr_q[i];
      return -1;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input string tag);
      for (int t = 0; t < 50; t++) begin
         if (!s_waitrequest) return;
         step();
      end
      check_eq({tag, "_timeout"}, 64'd1, 64'd0);
   endtask

   task automatic wr_burst(input int addr, input int n, input int bc, input logic [63:0] base,
                           input logic [7:0] be);
      for (int i = 0; i < n; i++) begin
         s_write      = 1'b1;
         s_address    = ADDR_W'(addr);
         s_burstcount = BURST_W'(bc);
         s_writedata  = base + 64'(i);
         s_byteenable = be;
         wait_ready("wr_accept");
         step();
      end
      s_write = 1'b0;
      step();
      step();
   endtask

   task automatic do_read(input int addr, input int bc, output int acc, output int whi);
      rd_data_q.delete();
      rd_cyc_q.delete();
      rd_issue_q.delete();
      s_read       = 1'b1;
      s_address    = ADDR_W'(addr);
      s_burstcount = BURST_W'(bc);
      wait_ready("rd_accept");
      acc = cyc;
      step();
      s_read = 1'b0;
      whi    = 0;
      for (int i = 0; i < 24; i++) begin
         if (s_waitrequest) whi++;
         step();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int acc, whi, n_before;

      // Reset values
      step();
      step();
      check_eq("rst_waitreq", 64'(s_waitrequest), 64'd1);
      check_eq("rst_clken", 64'(m_clken), 64'd0);
      check_eq("rst_rdv", 64'(s_readdatavalid), 64'd0);
      check_eq("rst_err", 64'(err_proto), 64'd0);
      check_eq("rst_cs", 64'(m_chipselect), 64'd0);
      reset_n = 1'b1;
      step();
      check_eq("post_rst_clken", 64'(m_clken), 64'd1);
      check_eq("post_rst_waitreq", 64'(s_waitrequest), 64'd0);

      // Single write then single read
      wr_burst(5, 1, 1, 64'h1122_3344_5566_7788, 8'hFF);
      do_read(5, 1, acc, whi);
      check_eq("single_cnt", 64'(rd_data_q.size()), 64'd1);
      check_eq("single_data", rd_data(0), 64'h1122_3344_5566_7788);
      check_eq("single_lat", 64'(rd_cyc(0) - acc), 64'd3);
      check_eq("single_whi", 64'(whi), 64'd0);

      // 16-beat wrapping burst write then read
      wr_burst(1020, 16, 16, 64'd0, 8'hFF);
      do_read(1020, 16, acc, whi);
      check_eq("b16_cnt", 64'(rd_data_q.size()), 64'd16);
      check_eq("b16_whi", 64'(whi), 64'd15);
      for (int i = 0; i < 16; i++) begin
         check_eq($sformatf("b16_data%0d", i), rd_data(i), 64'(i));
         check_eq($sformatf("b16_cyc%0d", i), 64'(rd_cyc(i) - acc), 64'(3 + i));
         check_eq($sformatf("b16_addr%0d", i), 64'(rd_issue(i)), 64'((1020 + i) % 1024));
      end
      check_eq("b16_err", 64'(err_proto), 64'd0);

      // Partial byteenable
      wr_burst(40, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
      wr_burst(40, 1, 1, 64'd0, 8'h0F);
      do_read(40, 1, acc, whi);
      check_eq("be_data", rd_data(0), 64'hFFFF_FFFF_0000_0000);

      // Write burst of 4 with a 2-cycle gap after beat 1
      wr_addr_q.delete();
      for (int i = 0; i < 4; i++) begin
         if (i == 2) begin
            s_write = 1'b0;
            step();
            check_eq("gap_cs0", 64'(m_chipselect), 64'd0);
            step();
            check_eq("gap_cs1", 64'(m_chipselect), 64'd0);
         end
         s_write      = 1'b1;
         s_address    = ADDR_W'(100);
         s_burstcount = BURST_W'(4);
         s_writedata  = 64'hA0 + 64'(i);
         s_byteenable = 8'hFF;
         wait_ready("gap_accept");
         step();
      end
      s_write = 1'b0;
      step();
      step();
      check_eq("gap_nwr", 64'(wr_addr_q.size()), 64'd4);
      for (int i = 0; i < 4; i++) begin
         check_eq($sformatf("gap_addr%0d", i), 64'(wr_addr(i)), 64'(100 + i));
      end
      do_read(100, 4, acc, whi);
      check_eq("gap_rd_lat", 64'(rd_cyc(0) - acc), 64'd3);
      check_eq("gap_rd_whi", 64'(whi), 64'd3);
      for (int i = 0; i < 4; i++) begin
         check_eq($sformatf("gap_rd%0d", i), rd_data(i), 64'hA0 + 64'(i));
      end
      check_eq("gap_err", 64'(err_proto), 64'd0);

      // Oversize burstcount clamps to 16 and flags an error
      do_read(1020, 20, acc, whi);
      check_eq("clamp_cnt", 64'(rd_data_q.size()), 64'd16);
      check_eq("clamp_last", rd_data(15), 64'd15);
      check_eq("clamp_whi", 64'(whi), 64'd15);
      check_eq("clamp_err", 64'(err_proto), 64'd1);

      // Reset during beat 7 of a 16-beat read
      rd_data_q.delete();
      rd_cyc_q.delete();
      s_read       = 1'b1;
      s_address    = ADDR_W'(1020);
      s_burstcount = BURST_W'(16);
      wait_ready("rst_rd_accept");
      step();
      s_read = 1'b0;
      for (int t = 0; t < 40 && rd_data_q.size() < 8; t++) begin
         @(negedge clk);
         #1;
      end
      check_eq("mid_beat7", rd_data(7), 64'd7);
      reset_n = 1'b0;
      #1;
      check_eq("mid_rdv_now", 64'(s_readdatavalid), 64'd0);
      n_before = rd_data_q.size();
      step();
      step();
      check_eq("mid_clken", 64'(m_clken), 64'd0);
      check_eq("mid_err_clr", 64'(err_proto), 64'd0);
      reset_n = 1'b1;
      for (int i = 0; i < 10; i++) step();
      check_eq("mid_no_more", 64'(rd_data_q.size()), 64'(n_before));
      do_read(0, 1, acc, whi);
      check_eq("mid_fresh_data", rd_data(0), 64'd4);
      check_eq("mid_fresh_lat", 64'(rd_cyc(0) - acc), 64'd3);

      // Read and write together: treated as a write, error flagged and sticky
      check_eq("both_err_pre", 64'(err_proto), 64'd0);
      s_read       = 1'b1;
      s_write      = 1'b1;
      s_address    = ADDR_W'(200);
      s_burstcount = BURST_W'(1);
      s_writedata  = 64'h55;
      s_byteenable = 8'hFF;
      wait_ready("both_accept");
      step();
      s_read  = 1'b0;
      s_write = 1'b0;
      step();
      step();
      check_eq("both_err", 64'(err_proto), 64'd1);
      do_read(200, 1, acc, whi);
      check_eq("both_data", rd_data(0), 64'h55);
      for (int i = 0; i < 5; i++) step();
      check_eq("both_err_sticky", 64'(err_proto), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/soc_system_onchip_ram_burst_bridge.md
Name: soc_system_onchip_ram_burst_bridge

Overview:
- Avalon-MM burst slave front end that sits directly upstream of the 1024 x 64-bit single-port on-chip RAM.
- Accepts pipelined read and write bursts from the HPS/fabric interconnect.
- Converts each burst into one single-beat RAM access per cycle, with registered RAM-side outputs.
- Returns read data with readdatavalid, preserving command order.

Parameters:
- ADDR_W, 10: RAM word-address width; addresses wrap modulo 2^ADDR_W.
- DATA_W, 64: data width.
- BE_W, 8: byteenable width (DATA_W/8).
- BURST_W, 5: burstcount width; maximum legal burst is 2^(BURST_W-1) = 16.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous active-low reset.
- s_address  in  ADDR_W  burst start word address.
- s_burstcount  in  BURST_W  beats in burst.
- s_read  in  1  read command.
- s_write  in  1  write command/beat.
- s_writedata  in  DATA_W  write beat data.
- s_byteenable  in  BE_W  write byte lanes.
- s_waitrequest  out  1  stall; the command/beat is accepted when s_read|s_write is high and s_waitrequest is low.
- s_readdata  out  DATA_W  registered read data.
- s_readdatavalid  out  1  read beat valid.
- err_proto  out  1  sticky protocol-error flag.
- m_address  out  ADDR_W  RAM address.
- m_byteenable  out  BE_W  RAM byte lanes.
- m_chipselect  out  1  RAM select.
- m_write  out  1  RAM write.
- m_writedata  out  DATA_W  RAM write data.
- m_clken  out  1  RAM clock enable; constant 1 after reset.
- m_readdata  in  DATA_W  RAM q; valid the cycle after the RAM samples its address.

Behaviour:
- Reset (async, reset_n low): state=IDLE.
  - All outputs 0 except s_waitrequest=1 and m_clken=0.
  - The first clock after reset_n deasserts sets m_clken=1 and s_waitrequest=0.
  - Reset mid-burst aborts the burst; in-flight read beats are discarded (readdatavalid pipeline cleared).
- FSM states: IDLE, RD_BURST, WR_BURST.
- IDLE: s_waitrequest=0.
  - s_read accepted: latch addr and count (burstcount 0 treated as 1; values above 16 clamped to 16 and err_proto set). Issue beat 0 next cycle. If count>1 go to RD_BURST, else stay in IDLE.
  - s_write accepted: register beat 0 onto m_* next cycle with m_write=1 and m_chipselect=1. If count>1 go to WR_BURST with remaining=count-1.
  - s_read and s_write both high: treated as a write; err_proto set.
- RD_BURST: s_waitrequest=1.
  - One RAM read issued per cycle (m_chipselect=1, m_write=0); address increments by 1 and wraps 1023->0.
  - After the last issue, return to IDLE, where s_waitrequest=0.
- WR_BURST: s_waitrequest=0.
  - Each cycle with s_write high accepts a beat: registered to m_* next cycle, address incremented with wrap.
  - s_write low inserts an idle cycle on m_* (m_chipselect=0); no timeout.
  - s_read high in WR_BURST is ignored and sets err_proto.
  - After the last beat, return to IDLE.
- Read latency: acceptance cycle = cycle 0; m_address driven in cycle 1; m_readdata valid in cycle 2; s_readdata/s_readdatavalid high in cycle 3. Subsequent beats follow back-to-back.
- A 3-deep valid shift pipeline tracks beats in flight. A new command may be accepted in IDLE while earlier read beats drain; order is preserved because the RAM is single-port and in-order.
- Read-after-write to the same address is issued in program order. Because the RAM port is DONT_CARE for read-during-write, the bridge never issues a read and a write in the same cycle (guaranteed by the single m_* register).
- err_proto clears only on reset.

Decomposition:
- Package soc_system_onchip_ram_pkg holds:
  - state enum (IDLE/RD_BURST/WR_BURST);
  - MAX_BURST=16;
  - READ_LATENCY=3;
  - address-increment-with-wrap function.
- One sub-module, soc_system_onchip_ram_rd_pipe: the valid shift register plus the s_readdata capture register, clearable by reset.

Test Plan:
- Single write then single read: write 0x1122334455667788 to addr 5 with byteenable 0xFF; read addr 5 -> readdatavalid exactly 3 cycles after acceptance, data 0x1122334455667788.
- Burst write of 16 beats at addr 1020 with data=i, then 16-beat read at 1020 -> beats return 0..15 on consecutive cycles; addresses seen on m_address are 1020..1023, 0..11; s_waitrequest high for 15 cycles.
- Partial byteenable: write 0xFFFF_FFFF_FFFF_FFFF, then write 0 with byteenable 0x0F -> read returns 0xFFFFFFFF00000000.
- Write burst of 4 with s_write deasserted for 2 cycles after beat 1 -> m_chipselect low for those 2 cycles; all 4 beats land at consecutive addresses; state returns to IDLE.
- s_read and s_write asserted together in IDLE; also burstcount=20 -> treated as write, burst clamped to 16 respectively; err_proto=1 and stays set.
- reset_n pulsed low during beat 7 of a 16-beat read -> s_readdatavalid=0 immediately with no further beats; after release, a fresh read of addr 0 returns correct data at 3-cycle latency.
